regfile_dump_engine: RTL and testbench
======================================

// Module: regfile_dump_engine
// PURPOSE
//   Sequential reader for the 32x32 register file: on a start pulse it walks read addresses
//   start_addr..end_addr (modulo 32), samples the combinational read data and streams each
//   {addr,data} beat out over a valid/ready handshake.
//   It sits beside the core's register file on a spare read port (A/RD pair) and feeds a debug/trace sink.
// PARAMETERS
//   ADDR_W   5   register address width; register count = 2**ADDR_W
//   DATA_W   32  register data width
//   ZERO_X0  1   1: beats for address 0 carry data 0 regardless of rf_rdata (RISC-V x0)
// PORTS
//   clk         in   1       single clock, all state on posedge
//   rst         in   1       asynchronous, active-high reset
//   start       in   1       dump request; sampled only in IDLE
//   start_addr  in   ADDR_W  first address; sampled with start
//   end_addr    in   ADDR_W  last address; sampled with start
//   abort       in   1       synchronous cancel of a dump in progress
//   rf_addr     out  ADDR_W  read address to register file port
//   rf_rdata    in   DATA_W  combinational read data for rf_addr (same cycle)
//   out_valid   out  1       beat valid
//   out_ready   in   1       sink accepts beat
//   out_addr    out  ADDR_W  address of current beat
//   out_data    out  DATA_W  data of current beat
//   out_last    out  1       current beat is end_addr
//   busy        out  1       high in READ/HOLD
//   done        out  1       one-cycle pulse after last beat accepted
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE; rf_addr=0, out_valid=0, out_addr=0, out_data=0,
//     out_last=0, busy=0, done=0; internal cur/end regs=0.
//   FSM IDLE -> READ -> HOLD -> (READ | DONE) -> IDLE.
//   IDLE: start=1 -> latch cur=start_addr, end=end_addr; next state READ. start otherwise ignored.
//   READ: rf_addr=cur (registered, valid this cycle); at the edge capture out_data=rf_rdata
//     (0 if ZERO_X0 && cur==0), out_addr=cur, out_last=(cur==end); out_valid<=1; -> HOLD.
//   HOLD: out_valid, out_addr, out_data, out_last held stable until out_valid&&out_ready.
//     On handshake: out_valid<=0; if out_last -> DONE, else cur<=cur+1 (wraps 31->0) -> READ.
//   DONE: done=1 for exactly one cycle, busy=0; -> IDLE.
//   Latency: start in IDLE at cycle n -> READ at n+1 -> first out_valid at n+2.
//   Throughput: one beat per 2 cycles max (READ+HOLD); out_ready held high gives valid
//     alternating 1/0.
//   Beat count = ((end_addr - start_addr) mod 2**ADDR_W) + 1; start_addr==end_addr -> 1 beat;
//     start_addr > end_addr wraps through 0.
//   Register file is not frozen: a core write landing before a register's READ cycle is visible.
//   abort=1 in READ/HOLD: next state IDLE, out_valid<=0 immediately (beat dropped), no done pulse;
//     abort has priority over handshake in the same cycle; abort in IDLE/DONE ignored.
//   start asserted while busy: ignored, no queuing.
//   rf_addr keeps its last value when idle (no read side effects).
//   Async reset mid-dump: all outputs to reset values at once; no done pulse.
// STRUCTURE
//   Shared package regdump_pkg: state enum {IDLE,READ,HOLD,DONE}, ADDR_W/DATA_W defaults,
//     beat struct {addr,data,last}.
//   Single module, no sub-module; one FSM process plus output holding registers.
// TESTING
//   T1 preload x6=0x40, x9=0x20; start 5..9, out_ready=1 -> beats addr 5,6,7,8,9,
//     data[6]=0x40, data[9]=0x20, out_last only on 9, done one cycle after 9 accepted.
//   T2 start 30..1 -> beats 30,31,0,1 in order; addr 0 data=0 with ZERO_X0=1 even if x0
//     preloaded 0xDEADBEEF.
//   T3 backpressure: out_ready low 4 cycles on beat 2 -> addr/data/last stable, out_valid
//     stays 1, no address skipped.
//   T4 abort during HOLD of beat 3 of 0..31 -> out_valid 0 next cycle, busy 0, done never pulses;
//     next start 2..2 gives one beat.
//   T5 start pulsed during busy and abort+handshake same cycle -> start ignored, beat dropped,
//     IDLE.
//   T6 rst=1 asynchronously mid-dump (between edges) -> outputs zero immediately; after release
//     start 0..0 dumps x0.

Source files
------------

// File: rtl/regdump_pkg.sv
// Shared types for the register-file dump engine: FSM states, default widths
// and the {addr,data,last} beat record used by consumers of the stream.
package regdump_pkg;

  localparam int unsigned ADDR_W_DFLT = 5;
  localparam int unsigned DATA_W_DFLT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_W_DFLT-1:0] addr;
    logic [DATA_W_DFLT-1:0] data;
    logic                   last;
  } beat_t;

endpackage

// File: rtl/regfile_dump_engine.sv
// Walks register-file addresses start..end (wrapping) on a spare read port and
// streams each {addr,data,last} beat over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; rf_addr keeps its last value
// READ  | rf_addr = cur, capture rf_rdata into the output beat
// HOLD  | beat presented, waiting for out_ready
// DONE  | one-cycle done pulse after the last beat was accepted
module regfile_dump_engine
  import regdump_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DFLT,
  parameter int unsigned DATA_W  = DATA_W_DFLT,
  parameter bit          ZERO_X0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  state_t              state_q,     state_d;
  logic [ADDR_W-1:0]   cur_q,       cur_d;
  logic [ADDR_W-1:0]   end_q,       end_d;
  logic [ADDR_W-1:0]   rf_addr_q,   rf_addr_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_addr_q,  out_addr_d;
  logic [DATA_W-1:0]   out_data_q,  out_data_d;
  logic                out_last_q,  out_last_d;
  logic [ADDR_W-1:0]   cur_inc;

  assign cur_inc = cur_q + ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      end_q       <= '0;
      rf_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      end_q       <= end_d;
      rf_addr_q   <= rf_addr_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // rf_addr is loaded on entry to READ so the read port already points at cur
  // during the READ cycle and rf_rdata can be captured at its closing edge.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    end_d       = end_q;
    rf_addr_d   = rf_addr_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cur_d     = start_addr;
          end_d     = end_addr;
          rf_addr_d = start_addr;
          state_d   = READ;
        end
      end

      READ: begin
        if (abort) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_addr_d  = cur_q;
          out_data_d  = (ZERO_X0 && (cur_q == '0)) ? '0 : rf_rdata;
          out_last_d  = (cur_q == end_q);
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end

      HOLD: begin
        // abort wins over a handshake in the same cycle: the beat is dropped
        if (abort) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = DONE;
          end else begin
            cur_d     = cur_inc;
            rf_addr_d = cur_inc;
            state_d   = READ;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rf_addr   = rf_addr_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == READ) || (state_q == HOLD);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_regfile_dump_engine.sv
// Scoreboard bench for regfile_dump_engine: stimulus pushes the expected beat
// list, a negedge monitor pops and compares every accepted beat and done pulse.
module tb_regfile_dump_engine;
  import regdump_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] end_addr;
  logic          abort;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] rf [32];
  assign rf_rdata = rf[rf_addr];

  always #5 clk = ~clk;

  regfile_dump_engine #(.ADDR_W(AW), .DATA_W(DW), .ZERO_X0(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .end_addr(end_addr), .abort(abort), .rf_addr(rf_addr), .rf_rdata(rf_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  beat_t exp_q[$];
  beat_t mon_e;
  beat_t hold_prev;
  bit    hold_pend = 1'b0;
  bit    done_exp  = 1'b0;
  int    n_chk = 0;
  int    n_pass = 0;
  int    n_acc = 0;
  bit    rand_ready = 1'b0;
  int    ready_pct = 100;

  function automatic void chk(string name, longint unsigned act, longint unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  function automatic void fail_now(string name);
    n_chk++;
    $display("FAIL %s: condition not met at %0t", name, $time);
  endfunction

  // Monitor: beats, hold stability under backpressure, done pulse timing.
  always @(negedge clk) begin
    if (rst) begin
      done_exp  = 1'b0;
      hold_pend = 1'b0;
    end else begin
      chk("done_pulse", done, done_exp);
      done_exp = 1'b0;
      if (hold_pend) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_addr", out_addr, hold_prev.addr);
        chk("hold_data", out_data, hold_prev.data);
        chk("hold_last", out_last, hold_prev.last);
      end
      hold_pend = 1'b0;
      if (out_valid && !abort) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_beat");
          end else begin
            mon_e = exp_q.pop_front();
            chk("beat_addr", out_addr, mon_e.addr);
            chk("beat_data", out_data, mon_e.data);
            chk("beat_last", out_last, mon_e.last);
            if (mon_e.last) done_exp = 1'b1;
            n_acc++;
          end
        end else begin
          hold_pend = 1'b1;
          hold_prev = '{addr: out_addr, data: out_data, last: out_last};
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(99) < ready_pct);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: beat count = ((e - s) mod 32) + 1, address 0 reads as zero.
  task automatic issue(input int s, input int e);
    int n;
    int a;
    n = ((e - s) & 31) + 1;
    for (int i = 0; i < n; i++) begin
      a = (s + i) & 31;
      exp_q.push_back('{addr: AW'(a), data: (a == 0) ? 32'd0 : rf[a], last: (i == n - 1)});
    end
    start_addr = AW'(s);
    end_addr   = AW'(e);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while ((busy || done || exp_q.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) begin
      fail_now(name);
      exp_q.delete();
    end
  endtask

  task automatic wait_acc(input int target, input string name);
    int k;
    k = 0;
    while (n_acc < target && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) fail_now(name);
  endtask

  int base;
  int k;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    start_addr = '0; end_addr = '0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_outs", {out_addr, out_data, out_last, rf_addr}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // T1: plain dump 5..9, ready held high
    rf[6] = 32'h40; rf[9] = 32'h20;
    out_ready = 1'b1;
    base = n_acc;
    issue(5, 9);
    chk("t1_busy_read", busy, 1);
    chk("t1_no_valid_yet", out_valid, 0);
    tick();
    chk("t1_first_valid", out_valid, 1);
    chk("t1_first_addr", out_addr, 5);
    tick();
    chk("t1_valid_alternates", out_valid, 0);
    wait_idle(200, "t1_timeout");
    chk("t1_beats", n_acc - base, 5);
    chk("t1_rf_addr_held", rf_addr, 9);

    // T2: wrap 30..1 with a poisoned x0
    rf[0] = 32'hDEADBEEF;
    base = n_acc;
    issue(30, 1);
    wait_idle(200, "t2_timeout");
    chk("t2_beats", n_acc - base, 4);

    // T3: backpressure on beat 2; register changes during HOLD must not leak out
    base = n_acc;
    issue(10, 14);
    wait_acc(base + 1, "t3_beat1_timeout");
    out_ready = 1'b0;
    tick();
    chk("t3_valid_in_hold", out_valid, 1);
    chk("t3_addr_in_hold", out_addr, 11);
    rf[11] = ~rf[11];
    for (int i = 0; i < 4; i++) tick();
    out_ready = 1'b1;
    wait_idle(200, "t3_timeout");
    chk("t3_beats", n_acc - base, 5);

    // T4: abort during HOLD of beat 3 of 0..31
    base = n_acc;
    issue(0, 31);
    wait_acc(base + 2, "t4_beat2_timeout");
    out_ready = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin tick(); k++; end
    chk("t4_hold_addr", out_addr, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    chk("t4_valid_dropped", out_valid, 0);
    chk("t4_busy_low", busy, 0);
    tick(); tick();
    chk("t4_beats", n_acc - base, 2);
    out_ready = 1'b1;
    base = n_acc;
    issue(2, 2);
    wait_idle(50, "t4_single_timeout");
    chk("t4_single_beat", n_acc - base, 1);

    // T5: start while busy is ignored; abort beats a same-cycle handshake
    out_ready = 1'b0;
    base = n_acc;
    issue(20, 25);
    tick();
    start_addr = 5'd3; end_addr = 5'd3; start = 1'b1;
    tick(); tick();
    start = 1'b0;
    chk("t5_start_ignored", out_addr, 20);
    abort = 1'b1; out_ready = 1'b1;
    tick();
    abort = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    chk("t5_valid_dropped", out_valid, 0);
    chk("t5_busy_low", busy, 0);
    tick(); tick();
    chk("t5_no_queued_start", busy, 0);
    chk("t5_beats", n_acc - base, 0);

    // T6: async reset between edges mid-dump
    out_ready = 1'b1;
    issue(8, 20);
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("t6_valid_zero", out_valid, 0);
    chk("t6_busy_zero", busy, 0);
    chk("t6_done_zero", done, 0);
    chk("t6_outs_zero", {out_addr, out_data, out_last, rf_addr}, 0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    rf[0] = 32'hDEADBEEF;
    base = n_acc;
    issue(0, 0);
    wait_idle(50, "t6_timeout");
    chk("t6_x0_beat", n_acc - base, 1);

    // Randomized dumps with random backpressure
    rand_ready = 1'b1;
    for (int r = 0; r < 25; r++) begin
      int s;
      int e;
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      ready_pct = 30 + $urandom_range(70);
      s = $urandom_range(31);
      e = $urandom_range(31);
      base = n_acc;
      issue(s, e);
      wait_idle(800, "rand_timeout");
      chk("rand_beats", n_acc - base, ((e - s) & 31) + 1);
    end
    rand_ready = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
